// File: rtl/gray_wptr_counter.sv
// gray_wptr_counter: binary + registered Gray write pointer with full/level.
// Optional macro GRAY_PTR_SYNC_EN adds a 2-flop synchronizer on rptr_gray_i.
module gray_wptr_counter #(
    parameter int width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_valid_i,
    output logic             inc_ready_o,
    input  logic [width:0]   rptr_gray_i,
    output logic [width:0]   wptr_gray_o,
    output logic [width:0]   wptr_bin_o,
    output logic [width-1:0] waddr_o,
    output logic             full_o,
    output logic [width:0]   level_o
);

    localparam int PW = width + 1;
    // Full when the two MSBs of the Gray pointers differ and the rest match.
    localparam logic [width:0] FULL_MASK = PW'(3) << (width - 1);

    logic [width:0] r_bin;
    logic [width:0] r_gray;
    logic [width:0] w_rs;
    logic [width:0] w_rs_bin;
    logic [width:0] w_bin_next;
    logic [width:0] w_full_cmp;
    logic           w_full;
    logic           w_accept;

`ifdef GRAY_PTR_SYNC_EN
    logic [width:0] r_sync1;
    logic [width:0] r_sync2;

    // Two-flop synchronizer bringing the read pointer into this domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= rptr_gray_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rs = r_sync2;
`else
    assign w_rs = rptr_gray_i;
`endif

    // Gray to binary: serial prefix XOR starting at the MSB.
    always_comb begin
        logic v_acc;
        v_acc    = 1'b0;
        w_rs_bin = '0;
        for (int i = width; i >= 0; i--) begin
            v_acc       = v_acc ^ w_rs[i];
            w_rs_bin[i] = v_acc;
        end
    end

    assign w_full_cmp = w_rs ^ FULL_MASK;
    assign w_full     = (r_gray == w_full_cmp);
    assign w_bin_next = r_bin + PW'(1);
    assign w_accept   = inc_valid_i & ~w_full & ~clr_i;

    // Pointer state: clear wins over accept; Gray is registered, never derived.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else if (clr_i) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else if (w_accept) begin
            r_bin  <= w_bin_next;
            r_gray <= w_bin_next ^ (w_bin_next >> 1);
        end
    end

    assign wptr_bin_o  = r_bin;
    assign wptr_gray_o = r_gray;
    assign waddr_o     = r_bin[width-1:0];
    assign full_o      = w_full;
    assign inc_ready_o = ~w_full;
    assign level_o     = r_bin - w_rs_bin;

endmodule

// File: tb/tb_gray_wptr_counter.sv
// tb_gray_wptr_counter: directed + random checks of gray_wptr_counter, width=2.
// Expected values come from a bench-side pointer model via a scoreboard queue.
module tb_gray_wptr_counter;

    localparam int W = 2;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       clr_i;
    logic       inc_valid_i;
    logic       inc_ready_o;
    logic [2:0] rptr_gray_i;
    logic [2:0] wptr_gray_o;
    logic [2:0] wptr_bin_o;
    logic [1:0] waddr_o;
    logic       full_o;
    logic [2:0] level_o;

    gray_wptr_counter #(.width(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .clr_i       (clr_i),
        .inc_valid_i (inc_valid_i),
        .inc_ready_o (inc_ready_o),
        .rptr_gray_i (rptr_gray_i),
        .wptr_gray_o (wptr_gray_o),
        .wptr_bin_o  (wptr_bin_o),
        .waddr_o     (waddr_o),
        .full_o      (full_o),
        .level_o     (level_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] gray;
        logic [2:0] bin;
        logic [2:0] level;
        logic [1:0] waddr;
        logic       full;
        logic       ready;
    } exp_t;

    exp_t q[$];
    int   n_asrt = 0;
    int   n_fail = 0;

    logic [2:0] mb;
    logic [2:0] s1;
    logic [2:0] s2;

    function automatic logic [2:0] g(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [2:0] g2b(input logic [2:0] x);
        logic [2:0] b;
        b[2] = x[2];
        b[1] = b[2] ^ x[1];
        b[0] = b[1] ^ x[0];
        return b;
    endfunction

    function automatic logic [2:0] rs_now();
`ifdef GRAY_PTR_SYNC_EN
        return s2;
`else
        return rptr_gray_i;
`endif
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic [2:0] rs;
        rs      = rs_now();
        e.gray  = g(mb);
        e.bin   = mb;
        e.level = mb - g2b(rs);
        e.waddr = mb[1:0];
        e.full  = (g(mb) == (rs ^ 3'b110));
        e.ready = ~e.full;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".gray"},  8'(wptr_gray_o), 8'(e.gray));
        chk({tag, ".bin"},   8'(wptr_bin_o),  8'(e.bin));
        chk({tag, ".level"}, 8'(level_o),     8'(e.level));
        chk({tag, ".waddr"}, 8'(waddr_o),     8'(e.waddr));
        chk({tag, ".full"},  8'(full_o),      8'(e.full));
        chk({tag, ".ready"}, 8'(inc_ready_o), 8'(e.ready));
    endtask

    // One clock: drive, advance the model, then compare after the edge.
    task automatic cyc(input string tag, input logic v, input logic c,
                       input logic [2:0] rp);
        exp_t e0;
        inc_valid_i = v;
        clr_i       = c;
        rptr_gray_i = rp;
        e0 = model();
        if (c) mb = 3'd0;
        else if (v && e0.ready) mb = mb + 3'd1;
`ifdef GRAY_PTR_SYNC_EN
        s2 = s1;
        s1 = rp;
`endif
        q.push_back(model());
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            n_asrt++;
            n_fail++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            chk_all(tag, q.pop_front());
        end
    endtask

    logic [2:0] gs [4];
    logic [2:0] prev;
    int         k;
    int         kmax;

    initial begin
        gs = '{3'b001, 3'b011, 3'b010, 3'b110};
        mb = 0; s1 = 0; s2 = 0;
        rst_ni = 1'b0; clr_i = 1'b0; inc_valid_i = 1'b0; rptr_gray_i = 3'd0;

        // Reset state
        #12;
        q.push_back(model());
        chk_all("reset", q.pop_front());
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: four accepts fill the FIFO
        for (int i = 0; i < 4; i++) begin
            cyc("t1", 1'b1, 1'b0, 3'd0);
            chk("t1_gray_seq", 8'(wptr_gray_o), 8'(gs[i]));
        end
        chk("t1_bin", 8'(wptr_bin_o), 8'h4);
        chk("t1_level", 8'(level_o), 8'h4);
        chk("t1_full", 8'(full_o), 8'h1);
        chk("t1_ready", 8'(inc_ready_o), 8'h0);

        // Test 2: held request while full, then read advances
        for (int i = 0; i < 10; i++) cyc("t2_hold", 1'b1, 1'b0, 3'd0);
        chk("t2_bin_held", 8'(wptr_bin_o), 8'h4);
        inc_valid_i = 1'b0;
        rptr_gray_i = 3'b001;
`ifndef GRAY_PTR_SYNC_EN
        #1;
        chk("t2_full_comb", 8'(full_o), 8'h0);
        chk("t2_level_comb", 8'(level_o), 8'h3);
`endif
        cyc("t2_rd1", 1'b0, 1'b0, 3'b001);
        cyc("t2_rd2", 1'b0, 1'b0, 3'b001);
        chk("t2_full_late", 8'(full_o), 8'h0);
        cyc("t2_clr", 1'b0, 1'b1, 3'd0);
        cyc("t2_idle", 1'b0, 1'b0, 3'd0);

        // Test 3: read tracks writes, 16 accepts wrap twice
        for (int i = 0; i < 16; i++) begin
            prev = wptr_gray_o;
            cyc("t3", 1'b1, 1'b0, g(mb));
            chk("t3_onebit", 8'($countones(wptr_gray_o ^ prev)), 8'h1);
            chk("t3_waddr", 8'(waddr_o), 8'((i + 1) % 4));
        end
        chk("t3_wrap_bin", 8'(wptr_bin_o), 8'h0);
        chk("t3_wrap_gray", 8'(wptr_gray_o), 8'h0);

        // Test 4: clear beats a simultaneous accept
        cyc("t4_sync", 1'b0, 1'b0, 3'd0);
        cyc("t4_sync", 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) cyc("t4_fill", 1'b1, 1'b0, 3'd0);
        chk("t4_bin3", 8'(wptr_bin_o), 8'h3);
        cyc("t4_clr", 1'b1, 1'b1, 3'd0);
        chk("t4_bin0", 8'(wptr_bin_o), 8'h0);
        chk("t4_gray0", 8'(wptr_gray_o), 8'h0);

        // Test 5: asynchronous reset between edges
        for (int i = 0; i < 3; i++) cyc("t5_fill", 1'b1, 1'b0, 3'd0);
        inc_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        mb = 0; s1 = 0; s2 = 0;
        #1;
        q.push_back(model());
        chk_all("t5_async_rst", q.pop_front());
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Test 6: random requests against a legal read pointer
`ifdef GRAY_PTR_SYNC_EN
        kmax = 2;
`else
        kmax = 4;
`endif
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, kmax);
            cyc("t6", 1'($urandom_range(0, 1)), 1'b0, g(mb - 3'(k)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

    // Bound the run in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
